out_port_arb: RTL and testbench

- Per-output-port wormhole arbiter and credit tracker for the mesh router; one instance per output port (N/E/S/W/local).
- Inputs whose decoded route selects this port (unicast or multicast forward/absorb) raise a request. The block picks one input round-robin and locks the port to it until that input's tail flit leaves.
- Flits are released only while the downstream buffer has credit.

---
 rtl/out_port_arb_if.sv | 24 ++
 rtl/out_port_arb.sv | 106 ++++++++++
 tb/tb_out_port_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/out_port_arb_if.sv
// Handshake/bus bundle between the router input stage (master) and one output-port arbiter (slave).
interface out_port_arb_if #(
    parameter int NUM_IN = 5,
    parameter int CNTW   = 3
);
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] tail;
    logic              credit_in;
    logic [NUM_IN-1:0] grant;
    logic              xfer;
    logic [CNTW-1:0]   credit_cnt;
    logic              busy;
    logic              ovf_err;

    modport master (
        output req, tail, credit_in,
        input  grant, xfer, credit_cnt, busy, ovf_err
    );

    modport slave (
        input  req, tail, credit_in,
        output grant, xfer, credit_cnt, busy, ovf_err
    );
endinterface

// File: rtl/out_port_arb.sv
// Wormhole round-robin output-port arbiter with downstream credit tracking; grant 1 cycle after req.
// Owner's flits stall (xfer low) while credit_cnt is 0 or owner req drops; others wait for owner's tail.
module out_port_arb #(
    parameter int NUM_IN    = 5,
    parameter int BUF_DEPTH = 4,
    parameter int CNTW      = 3
) (
    input  logic          clk,
    input  logic          rst_,
    out_port_arb_if.slave bus
);
    localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CNTW-1:0]   FULL = CNTW'(BUF_DEPTH);
    localparam logic [IDXW-1:0]   LAST = IDXW'(NUM_IN - 1);
    localparam logic [NUM_IN-1:0] ONE  = NUM_IN'(1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t            r_state;
    logic [NUM_IN-1:0] r_grant;
    logic [IDXW-1:0]   r_rr_ptr;
    logic              r_busy;
    logic [CNTW-1:0]   r_credit_cnt;
    logic              r_ovf_err;

    logic              w_win_vld;
    logic [IDXW-1:0]   w_win_idx;
    logic [IDXW-1:0]   w_scan_idx;
    logic              w_own_req;
    logic              w_own_tail;
    logic              w_xfer;

    // Scan from farthest to nearest so the closest requester after rr_ptr wins last.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_scan_idx = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            w_scan_idx = IDXW'((int'(r_rr_ptr) + k) % NUM_IN);
            if (bus.req[w_scan_idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_scan_idx;
            end
        end
    end

    assign w_own_req  = |(bus.req & r_grant);
    assign w_own_tail = |(bus.tail & r_grant);
    assign w_xfer     = (r_state == S_LOCKED) && w_own_req && (r_credit_cnt != '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= LAST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_state  <= S_LOCKED;
                        r_grant  <= ONE << w_win_idx;
                        r_rr_ptr <= w_win_idx;
                        r_busy   <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_xfer && w_own_tail) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A credit arriving with a full counter is dropped and flagged rather than wrapped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_credit_cnt <= FULL;
            r_ovf_err    <= 1'b0;
        end else begin
            case ({w_xfer, bus.credit_in})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt == FULL) begin
                        r_ovf_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.xfer       = w_xfer;
    assign bus.credit_cnt = r_credit_cnt;
    assign bus.busy       = r_busy;
    assign bus.ovf_err    = r_ovf_err;
endmodule

// File: tb/tb_out_port_arb.sv
// Directed bench: per-cycle expectations are queued by the driver and checked by a negedge monitor.
module tb_out_port_arb;
    localparam int NUM_IN    = 5;
    localparam int BUF_DEPTH = 4;
    localparam int CNTW      = 3;

    typedef struct {
        int         tag;
        logic [4:0] g;
        logic       x;
        logic [2:0] c;
        logic       b;
        logic       o;
    } exp_t;

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk = ~clk;

    out_port_arb_if #(.NUM_IN(NUM_IN), .CNTW(CNTW)) bus ();

    out_port_arb #(
        .NUM_IN(NUM_IN),
        .BUF_DEPTH(BUF_DEPTH),
        .CNTW(CNTW)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    exp_t exp_q[$];
    exp_t e_cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tnum    = 0;
    int   cnum    = 0;

    task automatic push_exp(input logic [4:0] g, input logic x, input logic [2:0] c,
                            input logic b, input logic o);
        exp_t e;
        e.tag = tnum * 100 + cnum;
        e.g = g; e.x = x; e.c = c; e.b = b; e.o = o;
        exp_q.push_back(e);
        cnum++;
    endtask

    task automatic cyc(input logic [4:0] rq, input logic [4:0] tl, input logic ci,
                       input logic [4:0] g, input logic x, input logic [2:0] c,
                       input logic b, input logic o);
        bus.req       = rq;
        bus.tail      = tl;
        bus.credit_in = ci;
        push_exp(g, x, c, b, o);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int t);
        tnum = t;
        cnum = 0;
        rst_ = 1'b0;
        bus.req       = '0;
        bus.tail      = '0;
        bus.credit_in = 1'b0;
        push_exp(5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            n_tests++;
            if (bus.grant !== e_cur.g || bus.xfer !== e_cur.x || bus.credit_cnt !== e_cur.c ||
                bus.busy !== e_cur.b || bus.ovf_err !== e_cur.o) begin
                n_fail++;
                $display("FAIL t%0d.c%0d got grant=%b xfer=%b cnt=%0d busy=%b ovf=%b want grant=%b xfer=%b cnt=%0d busy=%b ovf=%b",
                         e_cur.tag / 100, e_cur.tag % 100, bus.grant, bus.xfer, bus.credit_cnt,
                         bus.busy, bus.ovf_err, e_cur.g, e_cur.x, e_cur.c, e_cur.b, e_cur.o);
            end
        end
    end

    initial begin
        logic [4:0] oh;
        bus.req       = '0;
        bus.tail      = '0;
        bus.credit_in = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic grant, 3-flit packet, bubble, then next requester
        do_reset(1);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b00101, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b00101, 5'b00000, 0, 5'b00001, 1, 3'd4, 1, 0);
        cyc(5'b00101, 5'b00000, 0, 5'b00001, 1, 3'd3, 1, 0);
        cyc(5'b00101, 5'b00001, 0, 5'b00001, 1, 3'd2, 1, 0);
        cyc(5'b00101, 5'b00000, 0, 5'b00000, 0, 3'd1, 0, 0);
        cyc(5'b00101, 5'b00100, 0, 5'b00100, 1, 3'd1, 1, 0);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd0, 0, 0);

        // 2: all requesting single-flit packets, credit returned every cycle
        do_reset(2);
        cyc(5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd4, 0, 0);
        for (int i = 0; i < NUM_IN; i++) begin
            oh = 5'b00001 << i;
            cyc(5'b11111, 5'b11111, 1, oh, 1, 3'd4, 1, 1);
            cyc(5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd4, 0, 1);
        end
        cyc(5'b11111, 5'b11111, 1, 5'b00001, 1, 3'd4, 1, 1);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 1);

        // 3: credit exhaustion on a 6-flit packet from input 2
        do_reset(3);
        cyc(5'b00100, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        for (int k = 4; k >= 1; k--) begin
            cyc(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'(k), 1, 0);
        end
        cyc(5'b00100, 5'b00000, 0, 5'b00100, 0, 3'd0, 1, 0);
        cyc(5'b00100, 5'b00000, 1, 5'b00100, 0, 3'd0, 1, 0);
        cyc(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'd1, 1, 0);
        cyc(5'b00100, 5'b00000, 1, 5'b00100, 0, 3'd0, 1, 0);
        cyc(5'b00100, 5'b00100, 0, 5'b00100, 1, 3'd1, 1, 0);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd0, 0, 0);

        // 4: owner req drops mid-packet; others and their tails ignored
        do_reset(4);
        cyc(5'b00010, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b00010, 5'b00000, 0, 5'b00010, 1, 3'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b11101, 5'b11101, 0, 5'b00010, 0, 3'd3, 1, 0);
        end
        cyc(5'b11111, 5'b00010, 0, 5'b00010, 1, 3'd3, 1, 0);
        cyc(5'b11101, 5'b00000, 0, 5'b00000, 0, 3'd2, 0, 0);
        cyc(5'b00000, 5'b00000, 0, 5'b00100, 0, 3'd2, 1, 0);

        // 5: simultaneous xfer+credit, then overflow at full count stays sticky
        do_reset(5);
        cyc(5'b00001, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b00001, 5'b00000, 0, 5'b00001, 1, 3'd4, 1, 0);
        cyc(5'b00001, 5'b00000, 0, 5'b00001, 1, 3'd3, 1, 0);
        cyc(5'b00001, 5'b00000, 1, 5'b00001, 1, 3'd2, 1, 0);
        cyc(5'b00001, 5'b00001, 0, 5'b00001, 1, 3'd2, 1, 0);
        cyc(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd1, 0, 0);
        cyc(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd2, 0, 0);
        cyc(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 0, 0);
        cyc(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b00010, 5'b00010, 0, 5'b00000, 0, 3'd4, 0, 1);
        cyc(5'b00010, 5'b00010, 0, 5'b00010, 1, 3'd4, 1, 1);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd3, 0, 1);

        // 6: asynchronous reset mid-packet while locked to input 3
        do_reset(6);
        cyc(5'b01000, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b01000, 5'b00000, 0, 5'b01000, 1, 3'd4, 1, 0);
        cyc(5'b01000, 5'b00000, 0, 5'b01000, 1, 3'd3, 1, 0);
        bus.req       = 5'b01000;
        bus.tail      = 5'b00000;
        bus.credit_in = 1'b0;
        #2;
        rst_ = 1'b0;
        push_exp(5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        cyc(5'b01000, 5'b00000, 0, 5'b00000, 0, 3'd4, 0, 0);
        cyc(5'b01000, 5'b01000, 0, 5'b01000, 1, 3'd4, 1, 0);
        cyc(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd3, 0, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
